// File: rtl/gps_acq_sched.sv
// rtl/gps_acq_sched.sv - GPS acquisition scheduler: per-satellite peak table, threshold scan, result handshake
module gps_acq_sched #(
  parameter logic [11:0] THRESH         = 12'd2200,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        busy,
  output logic        ack_start,
  input  logic        corr_complete,
  input  logic [9:0]  code_phase,
  input  logic [15:0] doppler_omega,
  input  logic [47:0] sat_in,
  input  logic [95:0] integ_in,
  input  logic        search_complete,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [5:0]  res_sat,
  output logic [9:0]  res_code_phase,
  output logic [15:0] res_doppler,
  output logic [11:0] res_peak,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_UPDATE, S_SCAN, S_OUT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [11:0] tab_peak [0:31];
  logic [9:0]  tab_cp   [0:31];
  logic [15:0] tab_dop  [0:31];

  logic [5:0]  snap_sat   [0:7];
  logic [11:0] snap_integ [0:7];
  logic [9:0]  snap_cp;
  logic [15:0] snap_dop;

  logic        corr_q, search_q;
  logic        corr_rise, search_rise;
  logic [2:0]  lane;
  logic [5:0]  idx;
  logic        pending;
  logic [31:0] wd;

  logic [5:0]  lane_sat;
  logic [11:0] lane_integ;
  logic [4:0]  lane_tab;
  logic        lane_ok;
  logic [4:0]  scan_tab;
  logic        scan_hit;
  logic [32:0] wd_inc;
  logic        wd_hit;
  logic        ack_start_d, busy_d, done_d;

  assign corr_rise   = corr_complete & ~corr_q;
  assign search_rise = search_complete & ~search_q;

  // Satellite n lives in table slot n-1; sat 32 wraps to slot 31 via 5-bit subtraction.
  assign lane_sat   = snap_sat[lane];
  assign lane_integ = snap_integ[lane];
  assign lane_tab   = lane_sat[4:0] - 5'd1;
  assign lane_ok    = (lane_sat != 6'd0) && (lane_sat <= 6'd32);
  assign scan_tab   = idx[4:0] - 5'd1;
  assign scan_hit   = (tab_peak[scan_tab] >= THRESH);

  // wd holds the number of cycles elapsed since START (0 during START itself).
  assign wd_inc = {1'b0, wd} + 33'd1;
  assign wd_hit = ((state == S_RUN) || (state == S_UPDATE)) &&
                  (wd_inc >= {1'b0, TIMEOUT_CYCLES});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req) state_nx = S_START;
      S_START:  state_nx = S_RUN;
      S_RUN: begin
        if (wd_hit)                       state_nx = S_SCAN;
        else if (corr_rise)               state_nx = S_UPDATE;
        else if (search_rise || pending)  state_nx = S_SCAN;
      end
      S_UPDATE: begin
        if (lane == 3'd7)
          state_nx = (pending || search_rise || timeout || wd_hit) ? S_SCAN : S_RUN;
      end
      S_SCAN: begin
        if (scan_hit)            state_nx = S_OUT;
        else if (idx == 6'd32)   state_nx = S_DONE;
      end
      S_OUT: begin
        if (res_valid && res_ready)
          state_nx = (idx == 6'd33) ? S_DONE : S_SCAN;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ack_start_d = (state_nx == S_START);
    busy_d      = (state_nx != S_IDLE);
    done_d      = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      res_valid      <= 1'b0;
      res_sat        <= 6'd0;
      res_code_phase <= 10'd0;
      res_doppler    <= 16'd0;
      res_peak       <= 12'd0;
      corr_q         <= 1'b0;
      search_q       <= 1'b0;
      lane           <= 3'd0;
      idx            <= 6'd0;
      pending        <= 1'b0;
      wd             <= 32'd0;
      snap_cp        <= 10'd0;
      snap_dop       <= 16'd0;
      for (int i = 0; i < 32; i++) begin
        tab_peak[i] <= 12'd0;
        tab_cp[i]   <= 10'd0;
        tab_dop[i]  <= 16'd0;
      end
      for (int k = 0; k < 8; k++) begin
        snap_sat[k]   <= 6'd0;
        snap_integ[k] <= 12'd0;
      end
    end else begin
      corr_q    <= corr_complete;
      search_q  <= search_complete;
      ack_start <= ack_start_d;
      busy      <= busy_d;
      done      <= done_d;

      if (((state == S_RUN) || (state == S_UPDATE)) && (state_nx == S_SCAN))
        idx <= 6'd1;

      case (state)
        S_IDLE: begin
          if (req) begin
            timeout <= 1'b0;
            pending <= 1'b0;
            wd      <= 32'd0;
            for (int i = 0; i < 32; i++) begin
              tab_peak[i] <= 12'd0;
              tab_cp[i]   <= 10'd0;
              tab_dop[i]  <= 16'd0;
            end
          end
        end
        S_START: wd <= wd + 32'd1;
        S_RUN: begin
          wd <= wd + 32'd1;
          if (wd_hit) begin
            timeout <= 1'b1;
          end else if (corr_rise) begin
            snap_cp  <= code_phase;
            snap_dop <= doppler_omega;
            for (int k = 0; k < 8; k++) begin
              snap_sat[k]   <= sat_in[k*6 +: 6];
              snap_integ[k] <= integ_in[k*12 +: 12];
            end
            lane <= 3'd0;
            if (search_rise) pending <= 1'b1;
          end
        end
        S_UPDATE: begin
          wd   <= wd + 32'd1;
          lane <= lane + 3'd1;
          if (wd_hit)      timeout <= 1'b1;
          if (search_rise) pending <= 1'b1;
          // Strict compare: on a tie the earlier peak is kept.
          if (lane_ok && (lane_integ > tab_peak[lane_tab])) begin
            tab_peak[lane_tab] <= lane_integ;
            tab_cp[lane_tab]   <= snap_cp;
            tab_dop[lane_tab]  <= snap_dop;
          end
        end
        S_SCAN: begin
          idx <= idx + 6'd1;
          if (scan_hit) begin
            res_valid      <= 1'b1;
            res_sat        <= idx;
            res_code_phase <= tab_cp[scan_tab];
            res_doppler    <= tab_dop[scan_tab];
            res_peak       <= tab_peak[scan_tab];
          end
        end
        S_OUT: begin
          if (res_valid && res_ready) begin
            res_valid      <= 1'b0;
            res_sat        <= 6'd0;
            res_code_phase <= 10'd0;
            res_doppler    <= 16'd0;
            res_peak       <= 12'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_acq_sched.sv
// tb/tb_gps_acq_sched.sv - directed and randomized checks of gps_acq_sched against a peak-table model
module tb_gps_acq_sched;

  logic        clk = 1'b0;
  logic        rst, req, corr_complete, search_complete, res_ready;
  logic [9:0]  code_phase;
  logic [15:0] doppler_omega;
  logic [47:0] sat_in;
  logic [95:0] integ_in;
  logic        busy, ack_start, res_valid, done, timeout;
  logic [5:0]  res_sat;
  logic [9:0]  res_code_phase;
  logic [15:0] res_doppler;
  logic [11:0] res_peak;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;

  typedef struct {
    logic [5:0]  sat;
    logic [9:0]  cp;
    logic [15:0] dop;
    logic [11:0] peak;
  } res_t;

  res_t expq[$];
  int   m_peak [1:32];
  int   m_cp   [1:32];
  int   m_dop  [1:32];

  gps_acq_sched #(.THRESH(12'd2200), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .ack_start(ack_start),
    .corr_complete(corr_complete), .code_phase(code_phase),
    .doppler_omega(doppler_omega), .sat_in(sat_in), .integ_in(integ_in),
    .search_complete(search_complete), .res_valid(res_valid),
    .res_ready(res_ready), .res_sat(res_sat), .res_code_phase(res_code_phase),
    .res_doppler(res_doppler), .res_peak(res_peak), .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 1; s <= 32; s++) begin
      m_peak[s] = 0; m_cp[s] = 0; m_dop[s] = 0;
    end
  endtask

  // Lanes are applied in order, so a later lane sees an earlier lane's update.
  task automatic model_apply();
    int s, v;
    for (int k = 0; k < 8; k++) begin
      s = int'(sat_in[6*k +: 6]);
      v = int'(integ_in[12*k +: 12]);
      if (s >= 1 && s <= 32 && v > m_peak[s]) begin
        m_peak[s] = v;
        m_cp[s]   = int'(code_phase);
        m_dop[s]  = int'(doppler_omega);
      end
    end
  endtask

  task automatic build_expect();
    res_t e;
    expq.delete();
    for (int s = 1; s <= 32; s++) begin
      if (m_peak[s] >= 2200) begin
        e.sat = s[5:0]; e.cp = m_cp[s][9:0]; e.dop = m_dop[s][15:0]; e.peak = m_peak[s][11:0];
        expq.push_back(e);
      end
    end
  endtask

  task automatic set_lane(input int k, input int s, input int v);
    sat_in[6*k +: 6]    = s[5:0];
    integ_in[12*k +: 12] = v[11:0];
  endtask

  task automatic fill_lanes(input int s, input int v);
    for (int k = 0; k < 8; k++) set_lane(k, s, v);
  endtask

  task automatic do_req();
    req = 1'b1;
    tick();
    t_start = cyc;
    chk("ack_start_on_req", ack_start, 1);
    chk("busy_on_req", busy, 1);
    chk("timeout_clear_on_req", timeout, 0);
    req = 1'b0;
    tick();
    chk("ack_start_one_cycle", ack_start, 0);
    model_clear();
  endtask

  task automatic corr_edge(input int cp, input int dop);
    code_phase    = cp[9:0];
    doppler_omega = dop[15:0];
    corr_complete = 1'b1;
    tick();
    corr_complete = 1'b0;
    model_apply();
  endtask

  task automatic end_search();
    search_complete = 1'b1;
    tick();
    search_complete = 1'b0;
  endtask

  task automatic collect(input int hold_lo, input int hold_hi);
    int   guard = 0;
    int   hold;
    bit   done_seen = 0;
    res_t e;
    build_expect();
    while (!done_seen && guard < 3000) begin
      guard++;
      if (res_valid === 1'b1) begin
        if (expq.size() > 0) e = expq.pop_front();
        else e = '{sat: 6'd0, cp: 10'd0, dop: 16'd0, peak: 12'd0};
        chk("res_sat", res_sat, e.sat);
        chk("res_code_phase", res_code_phase, e.cp);
        chk("res_doppler", res_doppler, e.dop);
        chk("res_peak", res_peak, e.peak);
        hold = $urandom_range(hold_hi, hold_lo);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
          tick();
          chk("hold_valid", res_valid, 1);
          chk("hold_sat", res_sat, e.sat);
          chk("hold_cp", res_code_phase, e.cp);
          chk("hold_dop", res_doppler, e.dop);
          chk("hold_peak", res_peak, e.peak);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("valid_drop_after_accept", res_valid, 0);
        chk("sat_zero_when_invalid", res_sat, 0);
        chk("peak_zero_when_invalid", res_peak, 0);
      end else if (done === 1'b1) begin
        done_seen = 1;
      end else begin
        tick();
      end
    end
    chk("done_seen", done_seen, 1);
    chk("results_outstanding", expq.size(), 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int guard;
    int n, gap;
    rst = 1'b1; req = 1'b0; corr_complete = 1'b0; search_complete = 1'b0;
    res_ready = 1'b0; code_phase = '0; doppler_omega = '0; sat_in = '0; integ_in = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack_start, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sat", res_sat, 0);
    rst = 1'b0;
    tick();

    // single peak above threshold
    do_req();
    fill_lanes(0, 2048);
    for (int k = 0; k < 8; k++) set_lane(k, k + 1, 2048);
    set_lane(2, 3, 2500);
    corr_edge(517, 26);
    repeat (8) tick();
    req = 1'b1; tick(); req = 1'b0;
    chk("req_ignored_when_busy", ack_start, 0);
    chk("single_peak_model_cp", m_cp[3], 517);
    end_search();
    collect(0, 0);

    // ties keep the earliest; invalid sat ids ignored
    do_req();
    fill_lanes(0, 4000);
    set_lane(1, 5, 2300); set_lane(3, 33, 4095); set_lane(5, 40, 4000);
    corr_edge(10, 100); repeat (8) tick();
    corr_edge(20, 200); repeat (8) tick();
    end_search();
    collect(0, 1);

    do_req();
    fill_lanes(0, 4000);
    set_lane(1, 5, 2300);
    corr_edge(10, 1); repeat (8) tick();
    corr_edge(20, 2); repeat (8) tick();
    set_lane(1, 5, 2301);
    corr_edge(30, 3); repeat (8) tick();
    end_search();
    collect(0, 1);

    // long backpressure
    do_req();
    fill_lanes(0, 0);
    set_lane(0, 7, 3000); set_lane(6, 20, 2900);
    corr_edge(300, 16'hBEEF); repeat (8) tick();
    end_search();
    collect(20, 20);

    // search_complete during UPDATE: last lane still applied
    do_req();
    fill_lanes(0, 0);
    set_lane(0, 9, 2500);
    corr_edge(100, 5); repeat (8) tick();
    set_lane(0, 0, 0); set_lane(7, 9, 2600);
    corr_edge(200, 6);
    repeat (2) tick();
    search_complete = 1'b1; tick(); search_complete = 1'b0;
    collect(0, 1);
    chk("no_timeout_with_pending", timeout, 0);

    // watchdog expiry with threshold boundaries
    do_req();
    fill_lanes(0, 0);
    set_lane(0, 12, 2222); set_lane(1, 13, 2199); set_lane(2, 14, 2200);
    corr_edge(44, 55); repeat (8) tick();
    guard = 0;
    while (timeout !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    chk("timeout_latency", cyc - t_start, 100);
    collect(0, 2);
    chk("timeout_sticky", timeout, 1);
    do_req();
    end_search();
    collect(0, 0);

    // reset while a result is waiting
    do_req();
    fill_lanes(0, 0);
    set_lane(4, 1, 3000);
    corr_edge(1, 1); repeat (8) tick();
    end_search();
    guard = 0;
    while (res_valid !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("reset_test_result_seen", res_valid, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midout_rst_valid", res_valid, 0);
    chk("midout_rst_busy", busy, 0);
    chk("midout_rst_sat", res_sat, 0);
    chk("midout_rst_cp", res_code_phase, 0);
    chk("midout_rst_dop", res_doppler, 0);
    chk("midout_rst_peak", res_peak, 0);
    chk("midout_rst_done", done, 0);
    chk("midout_rst_ack", ack_start, 0);
    rst = 1'b0;
    tick();

    // randomized searches
    for (int r = 0; r < 10; r++) begin
      do_req();
      n = $urandom_range(5, 1);
      for (int c = 0; c < n; c++) begin
        for (int k = 0; k < 8; k++) set_lane(k, $urandom_range(40, 0), $urandom_range(4095, 1800));
        corr_edge($urandom_range(1023, 0), $urandom_range(65535, 0));
        if (c == n - 1 && ($urandom_range(2, 0) == 0)) begin
          repeat (2) tick();
          search_complete = 1'b1; tick(); search_complete = 1'b0;
        end else begin
          gap = $urandom_range(3, 0);
          repeat (8 + gap) tick();
          if (c == n - 1) end_search();
        end
      end
      collect(0, 3);
      chk("rand_no_timeout", timeout, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
